flow_table_lookup: RTL

- Read-side search engine for the switch's dual-port flow/MAC table RAM. The table RAM has registered read addresses and 1-cycle read latency.
- Accepts a key lookup request, then sequentially scans table entries through the RAM's secondary read port (dpra/dpo).
- Returns hit/miss, the matching index and the entry value.
- The table writer owns the primary port. This block never writes.

---
 rtl/flow_table_lookup_if.sv | 25 ++
 rtl/flow_table_lookup.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/flow_table_lookup_if.sv
// Request/response handshake bundle between a lookup client and the flow table search engine.
interface flow_table_lookup_if #(
    parameter int KWIDTH = 10,
    parameter int AWIDTH = 6,
    parameter int VWIDTH = 4
);
    logic              req_valid;
    logic              req_ready;
    logic [KWIDTH-1:0] req_key;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_hit;
    logic [AWIDTH-1:0] rsp_index;
    logic [VWIDTH-1:0] rsp_value;

    modport master (
        output req_valid, req_key, rsp_ready,
        input  req_ready, rsp_valid, rsp_hit, rsp_index, rsp_value
    );

    modport slave (
        input  req_valid, req_key, rsp_ready,
        output req_ready, rsp_valid, rsp_hit, rsp_index, rsp_value
    );
endinterface

// File: rtl/flow_table_lookup.sv
// Linear-scan key search over the flow/MAC table through the RAM's secondary read port.
// Returns the first (lowest index) valid entry whose key matches, plus hit/miss statistics.
module flow_table_lookup #(
    parameter int DWIDTH = 15,
    parameter int AWIDTH = 6,
    parameter int DEPTH  = 64,
    parameter int KWIDTH = 10
) (
    input  logic                clk,
    input  logic                reset,
    flow_table_lookup_if.slave  lk,
    output logic [AWIDTH-1:0]   ram_addr,
    input  logic [DWIDTH-1:0]   ram_dout,
    output logic                busy,
    input  logic                stat_clear,
    output logic [15:0]         hit_count,
    output logic [15:0]         miss_count
);
    localparam int VWIDTH = DWIDTH - 1 - KWIDTH;
    localparam logic [AWIDTH-1:0] LAST_IDX = AWIDTH'(DEPTH - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]        state_q,     state_d;
    logic [KWIDTH-1:0] key_q,       key_d;
    logic [AWIDTH-1:0] ram_addr_q,  ram_addr_d;
    logic [AWIDTH-1:0] chk_idx_q,   chk_idx_d;
    logic              chk_vld_q,   chk_vld_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_hit_q,   rsp_hit_d;
    logic [AWIDTH-1:0] rsp_index_q, rsp_index_d;
    logic [VWIDTH-1:0] rsp_value_q, rsp_value_d;
    logic [15:0]       hit_count_q, hit_count_d;
    logic [15:0]       miss_count_q, miss_count_d;

    logic              entry_vld;
    logic [KWIDTH-1:0] entry_key;
    logic [VWIDTH-1:0] entry_val;
    logic              entry_match;
    logic              hit_inc;
    logic              miss_inc;

    assign entry_vld   = ram_dout[DWIDTH-1];
    assign entry_key   = ram_dout[DWIDTH-2:VWIDTH];
    assign entry_val   = ram_dout[VWIDTH-1:0];
    assign entry_match = entry_vld && (entry_key == key_q);

    // ram_dout always reflects the address presented one cycle earlier, so chk_idx lags ram_addr by one.
    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        ram_addr_d  = ram_addr_q;
        chk_idx_d   = chk_idx_q;
        chk_vld_d   = chk_vld_q;
        rsp_valid_d = rsp_valid_q;
        rsp_hit_d   = rsp_hit_q;
        rsp_index_d = rsp_index_q;
        rsp_value_d = rsp_value_q;
        hit_inc     = 1'b0;
        miss_inc    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                chk_vld_d = 1'b0;
                if (lk.req_valid) begin
                    key_d      = lk.req_key;
                    ram_addr_d = '0;
                    state_d    = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (ram_addr_q != LAST_IDX) begin
                    ram_addr_d = ram_addr_q + 1'b1;
                end
                chk_idx_d = ram_addr_q;
                chk_vld_d = 1'b1;
                if (chk_vld_q && entry_match) begin
                    rsp_valid_d = 1'b1;
                    rsp_hit_d   = 1'b1;
                    rsp_index_d = chk_idx_q;
                    rsp_value_d = entry_val;
                    hit_inc     = 1'b1;
                    chk_vld_d   = 1'b0;
                    state_d     = ST_RESP;
                end else if (chk_vld_q && (chk_idx_q == LAST_IDX)) begin
                    rsp_valid_d = 1'b1;
                    rsp_hit_d   = 1'b0;
                    rsp_index_d = '0;
                    rsp_value_d = '0;
                    miss_inc    = 1'b1;
                    chk_vld_d   = 1'b0;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                chk_vld_d = 1'b0;
                if (lk.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    ram_addr_d  = '0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Saturating counters; a coincident clear beats the increment.
    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (stat_clear) begin
            hit_count_d  = '0;
            miss_count_d = '0;
        end else begin
            if (hit_inc && (hit_count_q != 16'hFFFF)) begin
                hit_count_d = hit_count_q + 16'd1;
            end
            if (miss_inc && (miss_count_q != 16'hFFFF)) begin
                miss_count_d = miss_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            key_q        <= '0;
            ram_addr_q   <= '0;
            chk_idx_q    <= '0;
            chk_vld_q    <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_hit_q    <= 1'b0;
            rsp_index_q  <= '0;
            rsp_value_q  <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            key_q        <= key_d;
            ram_addr_q   <= ram_addr_d;
            chk_idx_q    <= chk_idx_d;
            chk_vld_q    <= chk_vld_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_hit_q    <= rsp_hit_d;
            rsp_index_q  <= rsp_index_d;
            rsp_value_q  <= rsp_value_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign lk.req_ready = (state_q == ST_IDLE);
    assign lk.rsp_valid = rsp_valid_q;
    assign lk.rsp_hit   = rsp_hit_q;
    assign lk.rsp_index = rsp_index_q;
    assign lk.rsp_value = rsp_value_q;
    assign ram_addr     = ram_addr_q;
    assign busy         = (state_q != ST_IDLE);
    assign hit_count    = hit_count_q;
    assign miss_count   = miss_count_q;
endmodule
